// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory-controller port between the core
// (port 0) and the UART program loader (port 1). One transaction is accepted
// per cycle and registered onto the memory bus. A tag pipe remembers which
// port issued each read, so that the read data is flagged to that port.
// Arbitration is round-robin, or loader-first while prog is high.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog,
  input  logic              req0,
  input  logic              we0,
  input  logic [3:0]        en0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] dout0,
  input  logic              req1,
  input  logic              we1,
  input  logic [3:0]        en1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] dout1,
  output logic              mem_wea,
  output logic [3:0]        mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  // Port that won the most recent transfer; 1 after reset so the core wins
  // the first contention.
  logic              last;
  logic              xfer;
  logic              sel;
  logic              sel_we;
  logic [3:0]        sel_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  // Issue-cycle read marker and the port that issued it.
  logic              vld_p1;
  logic              port_p1;

  // Read tag pipe; index RD_LAT-1 lines up with mem_dout.
  logic [RD_LAT-1:0] vld_p2;
  logic [RD_LAT-1:0] port_p2;

  // ---- request stage: combinational grant and request mux ----

  // Port 1 wins under prog, when alone, or when port 0 was served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (Rst) begin
      gnt1 = req1 & (prog | ~req0 | ~last);
      gnt0 = req0 & ~gnt1;
    end
  end

  assign xfer     = gnt0 | gnt1;
  assign sel      = gnt1;
  assign sel_we   = sel ? we1   : we0;
  assign sel_en   = sel ? en1   : en0;
  assign sel_addr = sel ? addr1 : addr0;
  assign sel_din  = sel ? din1  : din0;

  // ---- issue stage: transaction registered onto the memory bus ----

  // Register the granted transaction; idle cycles strobe nothing but keep address/data.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      mem_wea  <= 1'b0;
      mem_en   <= 4'h0;
      mem_addr <= '0;
      mem_din  <= '0;
      vld_p1   <= 1'b0;
      port_p1  <= 1'b0;
      last     <= 1'b1;
    end else begin
      mem_wea <= 1'b0;
      mem_en  <= 4'h0;
      vld_p1  <= 1'b0;
      if (xfer) begin
        mem_wea  <= sel_we;
        mem_en   <= sel_en;
        mem_addr <= sel_addr;
        mem_din  <= sel_din;
        vld_p1   <= ~sel_we;
        port_p1  <= sel;
        last     <= sel;
      end
    end
  end

  // ---- return stage: tag pipe tracking reads through memory latency ----

  generate
    if (RD_LAT == 1) begin : g_tag_one
      // Single-stage tag: the issue-cycle tag lands directly at the output.
      always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
          vld_p2  <= '0;
          port_p2 <= '0;
        end else begin
          vld_p2  <= vld_p1;
          port_p2 <= port_p1;
        end
      end
    end else begin : g_tag_many
      // Shift the issue-cycle tag one stage per clock toward the output.
      always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
          vld_p2  <= '0;
          port_p2 <= '0;
        end else begin
          vld_p2  <= {vld_p2[RD_LAT-2:0], vld_p1};
          port_p2 <= {port_p2[RD_LAT-2:0], port_p1};
        end
      end
    end
  endgenerate

  assign rvalid0 = vld_p2[RD_LAT-1] & ~port_p2[RD_LAT-1];
  assign rvalid1 = vld_p2[RD_LAT-1] &  port_p2[RD_LAT-1];
  assign dout0   = mem_dout;
  assign dout1   = mem_dout;
  assign busy    = (|mem_en) | (|vld_p2);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory-controller port between the RISC-V core (port 0) and the UART program loader (port 1). It sits between both requesters and the memory controller. It accepts at most one transaction per cycle, registers it onto the memory bus, and routes read data back to the requester that issued it. Arbitration is round-robin during normal run and loader-priority while `prog` is high.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `RD_LAT`, 1, memory read latency in cycles from issue cycle to `mem_dout` valid (1..4)

- `clk`  in  1  single clock for the whole block
- `Rst`  in  1  reset; asynchronous, active-low
- `prog`  in  1  loader-priority mode
- `req0`  in  1  core request; `we0`, `en0`, `addr0`, `din0` stable while high
- `we0`  in  1  1 = write, 0 = read
- `en0`  in  4  byte enables
- `addr0`  in  ADDR_W  address
- `din0`  in  DATA_W  write data
- `gnt0`  out  1  accept; transfer occurs on an edge with `req0 & gnt0`
- `rvalid0`  out  1  read data valid for port 0
- `dout0`  out  DATA_W  read data
- `req1`, `we1`, `en1`, `addr1`, `din1`, `gnt1`, `rvalid1`, `dout1`: same as port 0, for the loader
- `mem_wea`  out  1  memory write enable
- `mem_en`  out  4  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_din`  out  DATA_W  memory write data
- `mem_dout`  in  DATA_W  memory read data
- `busy`  out  1  issue cycle active or read outstanding

## Operation
- **Grant logic.** `gnt0`/`gnt1` are combinational from `req0`, `req1`, `prog`, and the `last` pointer. They are one-hot or zero, and zero while `Rst` is low.
- **prog=1.** Port 1 has strict priority. Port 0 is granted only when `req1=0`.
- **prog=0, round-robin.** When both ports request, grant the port not equal to `last`. A single requester is always granted, so back-to-back grants to the same port are allowed.
- **`last` pointer.** Updated to the granted port on every transfer edge. It is not updated when no transfer occurs. It resets to 1, so port 0 wins the first contention.
- **Transfer edge.** The selected `we`/`en`/`addr`/`din` are registered onto `mem_wea`/`mem_en`/`mem_addr`/`mem_din`.
- **Issue cycle.** The cycle following the transfer edge, in which the transaction is on the memory bus.
- **Cycles with no transfer.**
  - `mem_en`=0 and `mem_wea`=0.
  - `mem_addr`/`mem_din` hold their last values.
- **Write with `en`=0.** Issued as-is (no-op at memory). The arbiter does not filter it.
- **Read tagging.** Each read issue pushes a {valid, port} tag into an `RD_LAT`-deep shift register. Writes and idle cycles push an invalid tag.
- **Read return.** When the tag at the pipe output is valid, assert `rvalid<port>` for exactly one cycle.
- **Read data.** `dout0` = `dout1` = `mem_dout` (pass-through). Data is meaningful only with the matching `rvalid`.
- **Withdrawal.** A requester may drop `req` without a grant. No transaction is issued.
- **Request switching.** `prog` may change at any time. It affects only grants computed after the change. In-flight reads still return to their issuing port.
- **`busy`.** `busy` = `mem_en!=0` OR any valid tag in the pipe.

## Timing
- **Reset values (`Rst` low):**
  - `mem_wea`=0, `mem_en`=0, `mem_addr`=0, `mem_din`=0
  - `gnt0`=`gnt1`=0, `rvalid0`=`rvalid1`=0, `busy`=0
  - tag pipe cleared, `last`=1
- **Reset mid-operation.** Outstanding reads are dropped and never produce `rvalid`. The first grant is possible in the first cycle after `Rst` deasserts.
- **Throughput.** One transfer per cycle, sustained indefinitely.
- **Latency.**
  - Issue cycle starts 1 edge after the transfer edge.
  - `rvalid` rises `RD_LAT`+1 edges after the transfer edge (2 edges for `RD_LAT`=1).
- **Read/write ordering.** A write issued at cycle n+1 does not disturb a read issued at cycle n. Tags keep read returns in issue order.
- **Simultaneous events.**
  - `rvalid` for an old read and `gnt` for a new transfer may occur in the same cycle.
  - `rvalid0` and `rvalid1` are never both high.

## Test plan
- **Reset mid-read.** Pulse `Rst` low during an outstanding read -> all outputs 0 immediately; no `rvalid` ever appears for the dropped read; `last`=1.
- **Single read, port 0.** With `RD_LAT`=1, `req0`=1, `we0`=0, `en0`=4'hF, `addr0`=32'h10, memory returns 32'hDEADBEEF -> `gnt0` high in the request cycle; `mem_en`=4'hF and `mem_addr`=32'h10 in the next cycle; `rvalid0`=1 with `dout0`=32'hDEADBEEF two edges after transfer; `rvalid1` stays 0.
- **Round-robin contention.** `prog`=0, both ports request reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; `rvalid` alternates with the same pattern, delayed `RD_LAT`+1 edges.
- **Loader priority.** `prog`=1, `req1` writes to 32'h0, 32'h4, 32'h8 while `req0` is held -> three consecutive `gnt1`, `mem_wea`=1 each issue cycle; `gnt0` only in the cycle after `req1` drops.
- **Mode switch with read in flight.** Port 0 read issued, then `prog` rises and port 1 writes -> `rvalid0` still returns on schedule; port 1 write issues in the following cycle; `busy` falls only after the last issue or return.
- **Withdrawal and `RD_LAT`=3.** `req1` raised then dropped while `gnt1`=0 with `prog`=0 and port 0 winning -> no port-1 issue. Separately, with `RD_LAT`=3, back-to-back port-0 reads to 32'h0 and 32'h4 -> `rvalid0` at edges 4 and 5 after the first transfer.
